fmul_normalize_round: RTL and testbench

- Downstream stage of the radix-4 Booth multiplier in the FP multiply path.
- Takes the raw significand product, the sign, the biased exponent sum and the special-case class from the FP multiply front end.
- Normalizes, rounds to IEEE-754 single precision, and produces the packed result plus RISC-V fflags.
- Hands the result to writeback through a valid/ready handshake. It back-pressures the multiplier via ready_o.

---
 rtl/fmul_normalize_round_pkg.sv | 30 +++
 rtl/lzc_48.sv | 21 ++
 rtl/fmul_normalize_round.sv | 198 +++++++++++++++++++
 tb/tb_fmul_normalize_round.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmul_normalize_round_pkg.sv
// Shared types and constants for the FP multiply normalize/round stage.
package fmul_normalize_round_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } round_mode_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_s;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORMALIZE,
    ST_ROUND,
    ST_OUTPUT
  } fmul_rnd_state_e;

  localparam logic [31:0] CANONICAL_NAN = 32'h7FC0_0000;
  localparam logic [30:0] MAX_FINITE    = 31'h7F7F_FFFF;

endpackage

// File: rtl/lzc_48.sv
// Combinational leading-zero counter over a 48-bit word.
module lzc_48 (
  input  logic [47:0] data_i,
  output logic [5:0]  count_o,
  output logic        all_zero_o
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_o    = 6'd0;
    all_zero_o = 1'b1;
    // Scanning upward lets the highest set bit win.
    for (int i = 0; i < 48; i++) begin
      if (data_i[i]) begin
        count_o    = 6'(47 - i);
        all_zero_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fmul_normalize_round.sv
// Normalizes and rounds a raw significand product to IEEE-754 single precision,
// producing the packed result and RISC-V fflags behind a valid/ready handshake.
module fmul_normalize_round
  import fmul_normalize_round_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int BIAS   = 127
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clk_en_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2*XLEN-1:0] product_i,
  input  logic              sign_i,
  input  logic [EXP_W+1:0]  exp_sum_i,
  input  logic              is_zero_i,
  input  logic              is_inf_i,
  input  logic              is_nan_i,
  input  logic              invalid_i,
  input  logic [2:0]        round_mode_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [31:0]       result_o,
  output logic [4:0]        fflags_o
);

  localparam int PW = 2 * MANT_W;
  localparam int EW = EXP_W + 3;
  localparam logic signed [EW-1:0] EXP_MAX = EW'(2 * BIAS + 1);
  localparam logic [4:0] SHAMT_SAT = 5'd26;

  fmul_rnd_state_e      state_q, state_d;
  logic [PW-1:0]        mant_q;
  logic signed [EW-1:0] exp_q;
  logic                 sign_q, zero_q, inf_q, nan_q, inv_q, tiny_q, sticky_q;
  logic [2:0]           rm_q;
  logic [31:0]          result_q;
  fflags_s              fflags_q;

  logic [5:0]           lz_cnt;
  logic                 lz_zero;
  logic [PW-1:0]        norm_shift, sticky_mask, mant_n;
  logic signed [EW-1:0] exp_n, exp_nn;
  logic [EW-1:0]        shamt_full;
  logic [4:0]           shamt;
  logic                 tiny_n, sticky_n;

  logic [MANT_W-1:0]    kept;
  logic [MANT_W:0]      sum;
  logic [MANT_W-2:0]    frac_r;
  logic signed [EW-1:0] exp_r;
  logic                 rnd_g, rnd_s, inc, ovf, ovf_inf;
  logic [31:0]          res_d;
  fflags_s              flags_d;

  logic unused_prod_hi;
  assign unused_prod_hi = ^product_i[2*XLEN-1:PW];

  lzc_48 u_lzc (
    .data_i    (mant_q),
    .count_o   (lz_cnt),
    .all_zero_o(lz_zero)
  );

  assign ready_o  = (state_q == ST_IDLE);
  assign valid_o  = (state_q == ST_OUTPUT);
  assign result_o = result_q;
  assign fflags_o = fflags_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (valid_i) state_d = ST_NORMALIZE;
      ST_NORMALIZE: state_d = ST_ROUND;
      ST_ROUND:     state_d = ST_OUTPUT;
      ST_OUTPUT:    if (ready_i) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Leading one goes to the top bit; tiny values are denormalized with sticky collection.
  always_comb begin
    norm_shift  = mant_q << lz_cnt;
    exp_n       = exp_q + EW'(1) - EW'(lz_cnt);
    tiny_n      = exp_n[EW-1] | (exp_n == '0);
    shamt_full  = EW'(1) - exp_n;
    shamt       = (shamt_full > EW'(SHAMT_SAT)) ? SHAMT_SAT : shamt_full[4:0];
    sticky_mask = (PW'(1) << shamt) - PW'(1);
    sticky_n    = tiny_n & (|(norm_shift & sticky_mask));
    mant_n      = tiny_n ? (norm_shift >> shamt) : norm_shift;
    exp_nn      = tiny_n ? '0 : exp_n;
  end

  always_comb begin
    kept  = mant_q[PW-1:PW-MANT_W];
    rnd_g = mant_q[PW-MANT_W-1];
    rnd_s = (|mant_q[PW-MANT_W-2:0]) | sticky_q;
    case (rm_q)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = (rnd_g | rnd_s) & sign_q;
      RM_RUP:  inc = (rnd_g | rnd_s) & ~sign_q;
      RM_RMM:  inc = rnd_g;
      default: inc = rnd_g & (rnd_s | kept[0]);
    endcase

    sum    = {1'b0, kept} + (MANT_W + 1)'(inc);
    exp_r  = exp_q;
    frac_r = sum[MANT_W-2:0];
    if (sum[MANT_W]) begin
      exp_r  = exp_q + EW'(1);
      frac_r = '0;
    end else if ((exp_q == '0) && sum[MANT_W-1]) begin
      // A subnormal that rounded up into the hidden bit is now the smallest normal.
      exp_r = EW'(1);
    end

    ovf = (exp_r >= EXP_MAX);
    case (rm_q)
      RM_RTZ:  ovf_inf = 1'b0;
      RM_RDN:  ovf_inf = sign_q;
      RM_RUP:  ovf_inf = ~sign_q;
      default: ovf_inf = 1'b1;
    endcase

    flags_d    = '0;
    flags_d.nv = inv_q;
    flags_d.of = ovf;
    flags_d.uf = tiny_q & (rnd_g | rnd_s);
    flags_d.nx = rnd_g | rnd_s | ovf;

    if (ovf) begin
      res_d = ovf_inf ? {sign_q, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}} : {sign_q, MAX_FINITE};
    end else begin
      res_d = {sign_q, exp_r[EXP_W-1:0], frac_r};
    end

    if (nan_q | inf_q | zero_q) begin
      flags_d    = '0;
      flags_d.nv = inv_q;
      if (nan_q)      res_d = CANONICAL_NAN;
      else if (inf_q) res_d = {sign_q, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
      else            res_d = {sign_q, 31'd0};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      mant_q   <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      inf_q    <= 1'b0;
      nan_q    <= 1'b0;
      inv_q    <= 1'b0;
      tiny_q   <= 1'b0;
      sticky_q <= 1'b0;
      rm_q     <= '0;
      result_q <= '0;
      fflags_q <= '0;
    end else if (clk_en_i) begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            mant_q   <= product_i[PW-1:0];
            exp_q    <= EW'($signed(exp_sum_i));
            sign_q   <= sign_i;
            zero_q   <= is_zero_i;
            inf_q    <= is_inf_i;
            nan_q    <= is_nan_i;
            inv_q    <= invalid_i;
            rm_q     <= round_mode_i;
            tiny_q   <= 1'b0;
            sticky_q <= 1'b0;
          end
        end
        ST_NORMALIZE: begin
          mant_q   <= mant_n;
          exp_q    <= exp_nn;
          tiny_q   <= tiny_n;
          sticky_q <= sticky_n;
          zero_q   <= zero_q | lz_zero;
        end
        ST_ROUND: begin
          result_q <= res_d;
          fflags_q <= flags_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fmul_normalize_round.sv
// Self-checking bench: directed vector table, randomized ops against an
// exact-arithmetic rounding model, plus handshake, reset and clock-enable sequences.
module tb_fmul_normalize_round;

  typedef struct {
    logic [63:0] product;
    logic [9:0]  exp_sum;
    logic        sign;
    logic        zero;
    logic        inf;
    logic        nan;
    logic        inv;
    logic [2:0]  rm;
    logic [31:0] exp_res;
    logic [4:0]  exp_flags;
  } vec_t;

  logic        clk, rst_n, clk_en, valid_i, ready_o, sign_i;
  logic        is_zero_i, is_inf_i, is_nan_i, invalid_i, valid_o, ready_i;
  logic [63:0] product_i;
  logic [9:0]  exp_sum_i;
  logic [2:0]  round_mode_i;
  logic [31:0] result_o;
  logic [4:0]  fflags_o;

  int checks   = 0;
  int failures = 0;
  vec_t tbl [18];

  fmul_normalize_round dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .clk_en_i    (clk_en),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .product_i   (product_i),
    .sign_i      (sign_i),
    .exp_sum_i   (exp_sum_i),
    .is_zero_i   (is_zero_i),
    .is_inf_i    (is_inf_i),
    .is_nan_i    (is_nan_i),
    .invalid_i   (invalid_i),
    .round_mode_i(round_mode_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .result_o    (result_o),
    .fflags_o    (fflags_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [63:0] p, input int e, input bit s, input logic [2:0] rm,
                               input logic [3:0] cls, input logic [31:0] res, input logic [4:0] fl);
    vec_t v;
    v.product = p;   v.exp_sum = 10'(e); v.sign = s; v.rm = rm;
    v.nan = cls[3];  v.inf = cls[2];     v.zero = cls[1]; v.inv = cls[0];
    v.exp_res = res; v.exp_flags = fl;
    return v;
  endfunction

  // Exact reference: pick the quantum position, split into truncated part and remainder,
  // then round by comparing the remainder against half a quantum.
  function automatic void model(input vec_t v, output logic [31:0] r, output logic [4:0] f);
    longint p, trunc, rem, half, mag;
    int m, e, q, eb, expo;
    bit inc, above, tie, nz, tiny, of, to_inf;
    p = longint'(v.product[47:0]);
    f = {v.inv, 4'b0000};
    if (v.nan)                  begin r = 32'h7FC0_0000; return; end
    if (v.inf)                  begin r = {v.sign, 8'hFF, 23'd0}; return; end
    if (v.zero || p == 0)       begin r = {v.sign, 31'd0}; return; end
    m = -1;
    for (int i = 47; i >= 0; i--) if (p[i] && m < 0) m = i;
    e    = int'($signed(v.exp_sum));
    eb   = m - 46 + e;
    tiny = (eb < 1);
    q    = (m - 23 > 24 - e) ? m - 23 : 24 - e;
    if (q <= 0) begin
      trunc = p << (-q); above = 0; tie = 0; nz = 0;
    end else if (q >= 49) begin
      trunc = 0; above = 0; tie = 0; nz = 1;
    end else begin
      trunc = p >> q;
      rem   = p & ((longint'(1) << q) - 1);
      half  = longint'(1) << (q - 1);
      above = (rem > half); tie = (rem == half); nz = (rem != 0);
    end
    case (v.rm)
      3'd1:    inc = 0;
      3'd2:    inc = nz & v.sign;
      3'd3:    inc = nz & ~v.sign;
      3'd4:    inc = above | tie;
      default: inc = above | (tie & trunc[0]);
    endcase
    mag = trunc + longint'(inc);
    if (mag == (longint'(1) << 24)) begin mag = longint'(1) << 23; q++; end
    expo = (mag >= (longint'(1) << 23)) ? q + e - 23 : 0;
    of   = (expo >= 255);
    case (v.rm)
      3'd1:    to_inf = 0;
      3'd2:    to_inf = v.sign;
      3'd3:    to_inf = ~v.sign;
      default: to_inf = 1;
    endcase
    if (of) r = to_inf ? {v.sign, 8'hFF, 23'd0} : {v.sign, 31'h7F7F_FFFF};
    else    r = {v.sign, expo[7:0], mag[22:0]};
    f = {v.inv, 1'b0, of, tiny & nz, nz | of};
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    logic [23:0] a, b;
    logic [47:0] p;
    int sc;
    a = {1'b1, 23'($urandom)};
    b = {1'b1, 23'($urandom)};
    case ($urandom_range(0, 4))
      0, 1:    p = 48'(a) * 48'(b);
      2:       p = {16'($urandom), 32'($urandom)};
      3:       p = 48'($urandom_range(0, 65535));
      default: p = {1'b0, a[22:0], 1'b1, 23'd0} << $urandom_range(0, 1);
    endcase
    v.product = {16'($urandom), p};
    case ($urandom_range(0, 3))
      0:       v.exp_sum = 10'($urandom_range(100, 160));
      1:       v.exp_sum = 10'(int'($urandom_range(0, 60)) - 30);
      2:       v.exp_sum = 10'($urandom_range(230, 280));
      default: v.exp_sum = 10'($urandom);
    endcase
    v.sign = 1'($urandom);
    v.rm   = 3'($urandom);
    sc     = $urandom_range(0, 9);
    v.nan  = (sc == 0); v.inf = (sc == 1); v.zero = (sc == 2);
    v.inv  = v.nan & 1'($urandom);
    v.exp_res = '0; v.exp_flags = '0;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    product_i = v.product; exp_sum_i = v.exp_sum; sign_i = v.sign; round_mode_i = v.rm;
    is_zero_i = v.zero;    is_inf_i = v.inf;      is_nan_i = v.nan; invalid_i = v.inv;
  endtask

  task automatic scramble();
    product_i = {$urandom, $urandom}; exp_sum_i = 10'($urandom); sign_i = 1'($urandom);
    round_mode_i = 3'($urandom); is_zero_i = 1'b0; is_inf_i = 1'b0; is_nan_i = 1'b0;
    invalid_i = 1'b0;
  endtask

  // Launch one op with ready_i high; returns at a negedge with the block back in IDLE.
  task automatic run_op(input vec_t v, input string tag, output logic [31:0] r, output logic [4:0] f);
    int n, lat;
    n = 0;
    while (!ready_o && n < 20) begin @(negedge clk); n++; end
    check($sformatf("%s ready_o before launch", tag), 64'(ready_o), 64'd1);
    apply(v);
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    scramble();
    lat = 1;
    while (!valid_o && lat < 20) begin @(negedge clk); lat++; end
    check($sformatf("%s latency", tag), 64'(lat), 64'd3);
    r = result_o;
    f = fflags_o;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r, er, held_r;
    logic [4:0]  f, ef, held_f;
    vec_t v;
    int n, seen;

    rst_n = 1'b0; clk_en = 1'b1; ready_i = 1'b1; valid_i = 1'b0;
    product_i = '0; exp_sum_i = '0; sign_i = 1'b0; round_mode_i = '0;
    is_zero_i = 1'b0; is_inf_i = 1'b0; is_nan_i = 1'b0; invalid_i = 1'b0;

    tbl[0]  = mkv(64'h4000_0000_0000, 127, 0, 3'd0, 4'b0000, 32'h3F80_0000, 5'b00000);
    tbl[1]  = mkv(64'h9000_0000_0000, 127, 0, 3'd0, 4'b0000, 32'h4010_0000, 5'b00000);
    tbl[2]  = mkv(64'h4000_0040_0000, 127, 0, 3'd0, 4'b0000, 32'h3F80_0000, 5'b00001);
    tbl[3]  = mkv(64'h4000_0040_0000, 127, 0, 3'd3, 4'b0000, 32'h3F80_0001, 5'b00001);
    tbl[4]  = mkv(64'h4000_0040_0000, 127, 0, 3'd1, 4'b0000, 32'h3F80_0000, 5'b00001);
    tbl[5]  = mkv(64'h8000_0000_0000, 254, 0, 3'd0, 4'b0000, 32'h7F80_0000, 5'b00101);
    tbl[6]  = mkv(64'h8000_0000_0000, 254, 0, 3'd1, 4'b0000, 32'h7F7F_FFFF, 5'b00101);
    tbl[7]  = mkv(64'h4000_0000_0000, 0,   0, 3'd0, 4'b0000, 32'h0040_0000, 5'b00000);
    tbl[8]  = mkv(64'h4000_0000_0001, 0,   0, 3'd0, 4'b0000, 32'h0040_0000, 5'b00011);
    tbl[9]  = mkv(64'h1234_5678_9ABC, 127, 0, 3'd0, 4'b1001, 32'h7FC0_0000, 5'b10000);
    tbl[10] = mkv(64'h4000_0000_0000, 127, 1, 3'd0, 4'b0010, 32'h8000_0000, 5'b00000);
    tbl[11] = mkv(64'h4000_0040_0000, 127, 0, 3'd4, 4'b0000, 32'h3F80_0001, 5'b00001);
    tbl[12] = mkv(64'h8000_0000_0000, 254, 0, 3'd2, 4'b0000, 32'h7F7F_FFFF, 5'b00101);
    tbl[13] = mkv(64'h8000_0000_0000, 254, 1, 3'd2, 4'b0000, 32'hFF80_0000, 5'b00101);
    tbl[14] = mkv(64'h4000_0000_0000, 127, 1, 3'd0, 4'b0100, 32'hFF80_0000, 5'b00000);
    tbl[15] = mkv(64'hFFFF_0000_0000_0000, 127, 1, 3'd0, 4'b0000, 32'h8000_0000, 5'b00000);
    tbl[16] = mkv(64'h7FFF_FF80_0000, 0, 0, 3'd0, 4'b0000, 32'h0080_0000, 5'b00011);
    tbl[17] = mkv(64'hFFFF_FF80_0000, 127, 0, 3'd7, 4'b0000, 32'h4080_0000, 5'b00001);

    #1;
    check("reset valid_o", 64'(valid_o), 64'd0);
    check("reset ready_o", 64'(ready_o), 64'd1);
    check("reset result_o", 64'(result_o), 64'd0);
    check("reset fflags_o", 64'(fflags_o), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset ready_o", 64'(ready_o), 64'd1);
    check("post-reset valid_o", 64'(valid_o), 64'd0);

    for (int i = 0; i < 18; i++) begin
      run_op(tbl[i], $sformatf("vec[%0d]", i), r, f);
      check($sformatf("vec[%0d] result", i), 64'(r), 64'(tbl[i].exp_res));
      check($sformatf("vec[%0d] fflags", i), 64'(f), 64'(tbl[i].exp_flags));
    end

    for (int k = 0; k < 300; k++) begin
      v = rand_vec();
      model(v, er, ef);
      run_op(v, $sformatf("rand[%0d]", k), r, f);
      check($sformatf("rand[%0d] result p=%h e=%0d rm=%0d", k, v.product[47:0], $signed(v.exp_sum), v.rm),
            64'(r), 64'(er));
      check($sformatf("rand[%0d] fflags p=%h e=%0d rm=%0d", k, v.product[47:0], $signed(v.exp_sum), v.rm),
            64'(f), 64'(ef));
    end

    // Back-pressure: result held while ready_i is low; a valid_i pulse there is ignored.
    ready_i = 1'b0;
    apply(tbl[1]);
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    scramble();
    n = 1;
    while (!valid_o && n < 20) begin @(negedge clk); n++; end
    check("bp latency", 64'(n), 64'd3);
    check("bp result", 64'(result_o), 64'(tbl[1].exp_res));
    held_r = result_o;
    held_f = fflags_o;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin apply(tbl[5]); valid_i = 1'b1; end
      else valid_i = 1'b0;
      @(negedge clk);
      check($sformatf("bp[%0d] valid_o", i), 64'(valid_o), 64'd1);
      check($sformatf("bp[%0d] ready_o", i), 64'(ready_o), 64'd0);
      check($sformatf("bp[%0d] result held", i), 64'(result_o), 64'(held_r));
      check($sformatf("bp[%0d] fflags held", i), 64'(fflags_o), 64'(held_f));
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    check("bp release ready_o", 64'(ready_o), 64'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid_o) seen = 1;
    end
    check("bp ignored pulse produced no result", 64'(seen), 64'd0);

    // Reset asserted while the op sits in ROUND aborts it.
    apply(tbl[1]);
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort valid_o", 64'(valid_o), 64'd0);
    check("abort ready_o", 64'(ready_o), 64'd1);
    check("abort result_o", 64'(result_o), 64'd0);
    check("abort fflags_o", 64'(fflags_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid_o) seen = 1;
    end
    check("abort no output pulse", 64'(seen), 64'd0);

    // Clock enable low freezes the pipeline mid-op and in OUTPUT.
    apply(tbl[0]);
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    clk_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("clk_en frozen[%0d] valid_o", i), 64'(valid_o), 64'd0);
      check($sformatf("clk_en frozen[%0d] ready_o", i), 64'(ready_o), 64'd0);
    end
    clk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("clk_en resume valid_o", 64'(valid_o), 64'd1);
    check("clk_en resume result", 64'(result_o), 64'h3F80_0000);
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("clk_en hold output[%0d]", i), 64'(valid_o), 64'd1);
    end
    clk_en = 1'b1;
    @(negedge clk);
    check("clk_en release ready_o", 64'(ready_o), 64'd1);

    run_op(tbl[3], "recover", r, f);
    check("recover result", 64'(r), 64'(tbl[3].exp_res));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
